// File: rtl/disp_scan_ctrl_pkg.sv
// Shared types, constants and digit helpers for the multiplexed display scanner.
package disp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SHOW = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam int NDIG  = 4;
    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] LT_CODE = 4'd8;

    function automatic logic [BCD_W-1:0] digit_of(input logic [NDIG*BCD_W-1:0] word,
                                                  input logic [1:0] idx);
        return word[{idx, 2'b00} +: BCD_W];
    endfunction

    // A digit is suppressed only if it and every more-significant digit are zero;
    // digit 0 always shows so a zero value still reads "0".
    function automatic logic lz_blank(input logic [NDIG*BCD_W-1:0] word,
                                      input logic [1:0] idx,
                                      input logic lzb);
        logic upper_zero;
        upper_zero = 1'b1;
        for (int i = 1; i < NDIG; i++) begin
            if (i >= int'(idx) && word[i*BCD_W +: BCD_W] != '0)
                upper_zero = 1'b0;
        end
        return lzb && (idx != 2'd0) && upper_zero;
    endfunction

endpackage

// File: rtl/disp_scan_ctrl_scan_timer.sv
// Loadable down-counter with a terminal-zero flag; it stops at zero until reloaded.
module scan_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (count != '0)
            count <= count - W'(1);
    end

    assign zero = (count == '0);

endmodule

// File: rtl/disp_scan_ctrl.sv
// Four-digit multiplexed display scanner: per-frame BCD snapshot, one lit digit at a
// time with a blank gap between digits, leading-zero suppression and lamp test.
module disp_scan_ctrl
    import disp_pkg::*;
#(
    parameter int DWELL = 250,
    parameter int GAP   = 4
) (
    input  logic                    CP,
    input  logic                    MRN,
    input  logic                    EN,
    input  logic [NDIG*BCD_W-1:0]   Dn,
    input  logic                    LZB,
    input  logic                    LT_N,
    output logic [BCD_W-1:0]        BCD,
    output logic                    BLANK,
    output logic [NDIG-1:0]         DIG_N,
    output logic                    FRAME,
    output state_t                  state_dbg
);

    localparam logic [15:0] DWELL_LD = 16'(DWELL - 1);
    localparam logic [15:0] GAP_LD   = 16'(GAP - 1);

    state_t                  state;
    logic [1:0]              idx;
    logic [NDIG*BCD_W-1:0]   snap;

    logic                    tmr_load;
    logic [15:0]             tmr_val;
    logic                    tmr_zero;

    logic [1:0]              next_idx;
    logic [NDIG*BCD_W-1:0]   next_snap;
    logic [BCD_W-1:0]        show_bcd;
    logic                    show_blank;
    logic [NDIG-1:0]         show_dig;

    scan_timer #(.W(16)) u_timer (
        .clk      (CP),
        .rst_n    (MRN),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    // Timer is reloaded on every phase change and parked at zero whenever idle.
    always_comb begin
        tmr_load = 1'b1;
        tmr_val  = '0;
        case (state)
            ST_IDLE: if (EN) tmr_val = DWELL_LD;
            ST_SHOW: begin
                if (EN && tmr_zero)  tmr_val  = GAP_LD;
                else if (EN)         tmr_load = 1'b0;
            end
            ST_GAP: begin
                if (EN && tmr_zero)  tmr_val  = DWELL_LD;
                else if (EN)         tmr_load = 1'b0;
            end
            default: ;
        endcase
    end

    // Digit and snapshot that the next SHOW cycle will present.
    always_comb begin
        next_idx  = idx;
        next_snap = snap;
        case (state)
            ST_IDLE: begin
                next_idx  = 2'd0;
                next_snap = Dn;
            end
            ST_GAP: begin
                next_idx = idx + 2'd1;
                if (idx == 2'd3) next_snap = Dn;
            end
            default: ;
        endcase
    end

    always_comb begin
        show_bcd   = LT_N ? digit_of(next_snap, next_idx) : LT_CODE;
        show_blank = LT_N ? lz_blank(next_snap, next_idx, LZB) : 1'b0;
        show_dig   = ~(4'b0001 << next_idx);
    end

    always_ff @(posedge CP or negedge MRN) begin
        if (!MRN) begin
            state <= ST_IDLE;
            idx   <= '0;
            snap  <= '0;
            BCD   <= '0;
            BLANK <= 1'b1;
            DIG_N <= 4'b1111;
            FRAME <= 1'b0;
        end else begin
            FRAME <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (EN) begin
                        state <= ST_SHOW;
                        idx   <= next_idx;
                        snap  <= next_snap;
                        FRAME <= 1'b1;
                        BCD   <= show_bcd;
                        BLANK <= show_blank;
                        DIG_N <= show_dig;
                    end else begin
                        BCD   <= '0;
                        BLANK <= 1'b1;
                        DIG_N <= 4'b1111;
                    end
                end
                ST_SHOW: begin
                    if (!EN) begin
                        state <= ST_IDLE;
                        BCD   <= '0;
                        BLANK <= 1'b1;
                        DIG_N <= 4'b1111;
                    end else if (tmr_zero) begin
                        state <= ST_GAP;
                        BLANK <= 1'b1;
                        DIG_N <= 4'b1111;
                    end else begin
                        BCD   <= show_bcd;
                        BLANK <= show_blank;
                        DIG_N <= show_dig;
                    end
                end
                ST_GAP: begin
                    if (!EN) begin
                        state <= ST_IDLE;
                        BCD   <= '0;
                        BLANK <= 1'b1;
                        DIG_N <= 4'b1111;
                    end else if (tmr_zero) begin
                        state <= ST_SHOW;
                        idx   <= next_idx;
                        snap  <= next_snap;
                        FRAME <= (idx == 2'd3);
                        BCD   <= show_bcd;
                        BLANK <= show_blank;
                        DIG_N <= show_dig;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed, table-driven bench for disp_scan_ctrl with DWELL=3, GAP=1.
module tb_disp_scan_ctrl;
    import disp_pkg::*;

    localparam int DWELL = 3;
    localparam int GAP   = 1;

    logic        CP   = 1'b0;
    logic        MRN  = 1'b1;
    logic        EN   = 1'b0;
    logic [15:0] Dn   = 16'h0000;
    logic        LZB  = 1'b0;
    logic        LT_N = 1'b1;
    logic [3:0]  BCD;
    logic        BLANK;
    logic [3:0]  DIG_N;
    logic        FRAME;
    state_t      state_dbg;

    disp_scan_ctrl #(.DWELL(DWELL), .GAP(GAP)) dut (
        .CP        (CP),
        .MRN       (MRN),
        .EN        (EN),
        .Dn        (Dn),
        .LZB       (LZB),
        .LT_N      (LT_N),
        .BCD       (BCD),
        .BLANK     (BLANK),
        .DIG_N     (DIG_N),
        .FRAME     (FRAME),
        .state_dbg (state_dbg)
    );

    always #5 CP = ~CP;

    typedef struct {
        logic        en;
        logic [15:0] dn;
        logic        lzb;
        logic        lt_n;
        logic [3:0]  bcd;
        logic        blank;
        logic [3:0]  dig;
        logic        frame;
    } vec_t;

    vec_t vecs[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    task automatic check_outs(input string tag, input logic [3:0] bcd, input logic blank,
                              input logic [3:0] dig, input logic frame);
        check($sformatf("%s_bcd", tag),   32'(BCD),   32'(bcd));
        check($sformatf("%s_blank", tag), 32'(BLANK), 32'(blank));
        check($sformatf("%s_dig_n", tag), 32'(DIG_N), 32'(dig));
        check($sformatf("%s_frame", tag), 32'(FRAME), 32'(frame));
    endtask

    task automatic add_vec(input logic en, input logic [15:0] dn, input logic lzb, input logic lt_n,
                           input logic [3:0] bcd, input logic blank, input logic [3:0] dig,
                           input logic frame);
        vec_t v;
        v.en = en; v.dn = dn; v.lzb = lzb; v.lt_n = lt_n;
        v.bcd = bcd; v.blank = blank; v.dig = dig; v.frame = frame;
        vecs.push_back(v);
    endtask

    task automatic add_idle(input logic [15:0] dn);
        add_vec(1'b0, dn, 1'b0, 1'b1, 4'h0, 1'b1, 4'b1111, 1'b0);
    endtask

    // One digit slot: DWELL lit cycles then GAP blank cycles with BCD held.
    task automatic add_slot(input logic [15:0] dn, input logic lzb, input logic lt_n,
                            input logic [3:0] bcd, input logic blank, input logic [3:0] dig,
                            input logic frame);
        for (int i = 0; i < DWELL; i++)
            add_vec(1'b1, dn, lzb, lt_n, bcd, blank, dig, (i == 0) ? frame : 1'b0);
        for (int i = 0; i < GAP; i++)
            add_vec(1'b1, dn, lzb, lt_n, bcd, 1'b1, 4'b1111, 1'b0);
    endtask

    task automatic apply(input vec_t v);
        EN   = v.en;
        Dn   = v.dn;
        LZB  = v.lzb;
        LT_N = v.lt_n;
        @(posedge CP);
        #1;
    endtask

    initial begin
        // idle after reset
        add_idle(16'h0000); add_idle(16'h0000); add_idle(16'h4321);
        // scan order
        add_slot(16'h4321, 1'b0, 1'b1, 4'h1, 1'b0, 4'b1110, 1'b1);
        add_slot(16'h4321, 1'b0, 1'b1, 4'h2, 1'b0, 4'b1101, 1'b0);
        add_slot(16'h4321, 1'b0, 1'b1, 4'h3, 1'b0, 4'b1011, 1'b0);
        add_slot(16'h4321, 1'b0, 1'b1, 4'h4, 1'b0, 4'b0111, 1'b0);
        // leading-zero suppression on
        add_slot(16'h0050, 1'b1, 1'b1, 4'h0, 1'b0, 4'b1110, 1'b1);
        add_slot(16'h0050, 1'b1, 1'b1, 4'h5, 1'b0, 4'b1101, 1'b0);
        add_slot(16'h0050, 1'b1, 1'b1, 4'h0, 1'b1, 4'b1011, 1'b0);
        add_slot(16'h0050, 1'b1, 1'b1, 4'h0, 1'b1, 4'b0111, 1'b0);
        // leading-zero suppression off
        add_slot(16'h0050, 1'b0, 1'b1, 4'h0, 1'b0, 4'b1110, 1'b1);
        add_slot(16'h0050, 1'b0, 1'b1, 4'h5, 1'b0, 4'b1101, 1'b0);
        add_slot(16'h0050, 1'b0, 1'b1, 4'h0, 1'b0, 4'b1011, 1'b0);
        add_slot(16'h0050, 1'b0, 1'b1, 4'h0, 1'b0, 4'b0111, 1'b0);
        // lamp test overrides blanking in SHOW only
        add_slot(16'h0050, 1'b1, 1'b0, 4'h8, 1'b0, 4'b1110, 1'b1);
        add_slot(16'h0050, 1'b1, 1'b0, 4'h8, 1'b0, 4'b1101, 1'b0);
        add_slot(16'h0050, 1'b1, 1'b0, 4'h8, 1'b0, 4'b1011, 1'b0);
        add_slot(16'h0050, 1'b1, 1'b0, 4'h8, 1'b0, 4'b0111, 1'b0);
        // frame coherence: Dn changes during digit 1
        add_slot(16'h1111, 1'b0, 1'b1, 4'h1, 1'b0, 4'b1110, 1'b1);
        add_slot(16'h9999, 1'b0, 1'b1, 4'h1, 1'b0, 4'b1101, 1'b0);
        add_slot(16'h9999, 1'b0, 1'b1, 4'h1, 1'b0, 4'b1011, 1'b0);
        add_slot(16'h9999, 1'b0, 1'b1, 4'h1, 1'b0, 4'b0111, 1'b0);
        add_slot(16'h9999, 1'b0, 1'b1, 4'h9, 1'b0, 4'b1110, 1'b1);
        add_slot(16'h9999, 1'b0, 1'b1, 4'h9, 1'b0, 4'b1101, 1'b0);
        // EN drop mid-dwell, then restart with fresh snapshot (codes >9 pass through)
        add_vec(1'b1, 16'h9999, 1'b0, 1'b1, 4'h9, 1'b0, 4'b1011, 1'b0);
        add_vec(1'b0, 16'h9999, 1'b0, 1'b1, 4'h0, 1'b1, 4'b1111, 1'b0);
        add_idle(16'hFEDC);
        add_slot(16'hFEDC, 1'b0, 1'b1, 4'hC, 1'b0, 4'b1110, 1'b1);
        add_slot(16'hFEDC, 1'b0, 1'b1, 4'hD, 1'b0, 4'b1101, 1'b0);
        add_vec(1'b1, 16'hFEDC, 1'b0, 1'b1, 4'hE, 1'b0, 4'b1011, 1'b0);

        // asynchronous reset, held across edges even with EN high
        #2 MRN = 1'b0;
        #1;
        check_outs("rst_async", 4'h0, 1'b1, 4'b1111, 1'b0);
        check("rst_async_state", 32'(state_dbg), 32'(ST_IDLE));
        EN = 1'b1;
        repeat (2) @(posedge CP);
        #1;
        check_outs("rst_hold", 4'h0, 1'b1, 4'b1111, 1'b0);
        EN = 1'b0;
        @(negedge CP);
        MRN = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
            check_outs($sformatf("vec%0d", i), vecs[i].bcd, vecs[i].blank, vecs[i].dig, vecs[i].frame);
        end

        // MRN asserted mid-dwell clears outputs without a clock edge
        #3 MRN = 1'b0;
        #1;
        check_outs("mid_rst", 4'h0, 1'b1, 4'b1111, 1'b0);
        check("mid_rst_state", 32'(state_dbg), 32'(ST_IDLE));
        Dn = 16'h0007;
        EN = 1'b1;
        @(negedge CP);
        MRN = 1'b1;
        @(posedge CP);
        #1;
        check_outs("restart", 4'h7, 1'b0, 4'b1110, 1'b1);
        check("restart_state", 32'(state_dbg), 32'(ST_SHOW));
        @(posedge CP);
        #1;
        check_outs("restart_hold", 4'h7, 1'b0, 4'b1110, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
